// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants, derived sync windows and colour codes
// shared by the sync generator and anything that drives graph_rgb.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  // Sync windows are half-open: [START, END)
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [2:0] rgb_t;

  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t GREEN = 3'b010;
  localparam rgb_t WHITE = 3'b111;

  // 11 bits so a window edge of 1024 still compares correctly against a 10-bit counter
  function automatic logic in_window(input logic [10:0] v, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with async reset to a per-bit value; DEPTH=0 is a
// straight wire so the caller can tune latency down to zero.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK | RESET;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters plus sync/video decode, delayed to line up with the text
// generator's pipeline, and final blanking of its colour onto the connector pins.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter int CLK_DIV   = 1,
  parameter int PIPE_DLY  = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] graph_rgb,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_tick
);

  localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO       = H_DISPLAY + H_FRONT;
  localparam int HS_HI       = HS_LO + H_SYNC;
  localparam int VS_LO       = V_DISPLAY + V_FRONT;
  localparam int VS_HI       = VS_LO + V_SYNC;
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       X_MAX   = 10'(LINE_LEN - 1);
  localparam logic [9:0]       Y_MAX   = 10'(FRAME_LINES - 1);
  // Delay-line bit order is {hsync, vsync, video}; syncs idle high
  localparam logic [2:0]       DLY_RST = 3'b110;

  logic [DIV_W-1:0] div_cnt;
  logic             pix_tick;
  logic             x_wrap;
  logic             y_wrap;
  logic             video_raw;
  logic             hsync_raw;
  logic             vsync_raw;
  logic [2:0]       dly_out;

  assign pix_tick = (div_cnt == DIV_MAX);
  assign x_wrap   = (pix_x == X_MAX);
  assign y_wrap   = (pix_y == Y_MAX);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // frame_tick is armed only by a real wrap, so the (0,0) after reset never pulses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pix_x      <= '0;
      pix_y      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_tick && x_wrap && y_wrap;
      if (pix_tick) begin
        if (x_wrap) begin
          pix_x <= '0;
          pix_y <= y_wrap ? '0 : pix_y + 10'd1;
        end else begin
          pix_x <= pix_x + 10'd1;
        end
      end
    end
  end

  assign video_raw = ({1'b0, pix_x} < 11'(H_DISPLAY)) && ({1'b0, pix_y} < 11'(V_DISPLAY));
  assign hsync_raw = !in_window({1'b0, pix_x}, 11'(HS_LO), 11'(HS_HI));
  assign vsync_raw = !in_window({1'b0, pix_y}, 11'(VS_LO), 11'(VS_HI));

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DLY_RST)
  ) u_sync_delay_line (
    .CLK   (CLK),
    .RESET (RESET),
    .din   ({hsync_raw, vsync_raw, video_raw}),
    .dout  (dly_out)
  );

  // graph_rgb is already PIPE_DLY behind the counters, so it pairs with dly_out here
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= BLACK;
    end else begin
      hsync    <= dly_out[2];
      vsync    <= dly_out[1];
      video_on <= dly_out[0];
      rgb      <= dly_out[0] ? graph_rgb : BLACK;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Drives four vga_sync_gen instances (full timing and three reduced rasters with
// different CLK_DIV / PIPE_DLY) and checks each against a cycle-count raster model.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int hd, hf, hs, hb;
    int vd, vf, vs, vb;
    int div, dly;
  } cfg_t;

  localparam int NI = 4;

  logic       CLK;
  logic       RESET;
  logic [2:0] graph_rgb;

  logic [9:0] ox   [NI];
  logic [9:0] oy   [NI];
  logic       ovid [NI];
  logic       ohs  [NI];
  logic       ovs  [NI];
  logic [2:0] orgb [NI];
  logic       oft  [NI];

  cfg_t       cfg  [NI];
  int         n_cmp = 0;
  int         n_bad = 0;
  longint     n;
  logic [2:0] g_edge;
  bit         white_mode;

  longint     t_hs_start [NI];
  longint     t_hs_fall  [NI];
  longint     t_vs_fall  [NI];
  longint     t_ft       [NI];
  int         run_len    [NI];
  bit         run_ok     [NI];
  logic [9:0] prev_x     [NI];
  logic       prev_hs    [NI];
  logic       prev_vs    [NI];

  vga_sync_gen u_def (
    .CLK(CLK), .RESET(RESET), .graph_rgb(graph_rgb),
    .pix_x(ox[0]), .pix_y(oy[0]), .video_on(ovid[0]), .hsync(ohs[0]),
    .vsync(ovs[0]), .rgb(orgb[0]), .frame_tick(oft[0]));

  vga_sync_gen #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .CLK_DIV(1), .PIPE_DLY(2)
  ) u_small (
    .CLK(CLK), .RESET(RESET), .graph_rgb(graph_rgb),
    .pix_x(ox[1]), .pix_y(oy[1]), .video_on(ovid[1]), .hsync(ohs[1]),
    .vsync(ovs[1]), .rgb(orgb[1]), .frame_tick(oft[1]));

  vga_sync_gen #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .CLK_DIV(4), .PIPE_DLY(2)
  ) u_div (
    .CLK(CLK), .RESET(RESET), .graph_rgb(graph_rgb),
    .pix_x(ox[2]), .pix_y(oy[2]), .video_on(ovid[2]), .hsync(ohs[2]),
    .vsync(ovs[2]), .rgb(orgb[2]), .frame_tick(oft[2]));

  vga_sync_gen #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .CLK_DIV(1), .PIPE_DLY(0)
  ) u_p0 (
    .CLK(CLK), .RESET(RESET), .graph_rgb(graph_rgb),
    .pix_x(ox[3]), .pix_y(oy[3]), .video_on(ovid[3]), .hsync(ohs[3]),
    .vsync(ovs[3]), .rgb(orgb[3]), .frame_tick(oft[3]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int h_tot(input cfg_t c);
    return c.hd + c.hf + c.hs + c.hb;
  endfunction

  function automatic int v_tot(input cfg_t c);
    return c.vd + c.vf + c.vs + c.vb;
  endfunction

  // Raster position and raw flags after n clock edges since reset release
  function automatic void raw_at(input cfg_t c, input longint t, output int x, output int y,
                                 output bit vid, output bit hs, output bit vs);
    longint p;
    p   = t / c.div;
    x   = int'(p % h_tot(c));
    y   = int'((p / h_tot(c)) % v_tot(c));
    vid = (x < c.hd) && (y < c.vd);
    hs  = !((x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs));
    vs  = !((y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_inst(input int i);
    int  ex, ey, dx, dy;
    bit  rvid, rhs, rvs, evid, ehs, evs, eft;
    logic [2:0] ergb;
    raw_at(cfg[i], n, ex, ey, rvid, rhs, rvs);
    if (n < cfg[i].dly + 1) begin
      evid = 1'b0; ehs = 1'b1; evs = 1'b1;
    end else begin
      raw_at(cfg[i], n - cfg[i].dly - 1, dx, dy, evid, ehs, evs);
    end
    ergb = evid ? g_edge : 3'b000;
    eft  = (n > 0) && (n % (longint'(h_tot(cfg[i])) * v_tot(cfg[i]) * cfg[i].div) == 0);
    check($sformatf("u%0d.pix_x", i), 32'(ox[i]), 32'(ex));
    check($sformatf("u%0d.pix_y", i), 32'(oy[i]), 32'(ey));
    check($sformatf("u%0d.video_on", i), 32'(ovid[i]), 32'(evid));
    check($sformatf("u%0d.hsync", i), 32'(ohs[i]), 32'(ehs));
    check($sformatf("u%0d.vsync", i), 32'(ovs[i]), 32'(evs));
    check($sformatf("u%0d.rgb", i), 32'(orgb[i]), 32'(ergb));
    check($sformatf("u%0d.frame_tick", i), 32'(oft[i]), 32'(eft));
  endtask

  // Interval measurements: sync delay and widths, frame period, visible run length
  task automatic track_inst(input int i);
    int hs_start;
    hs_start = cfg[i].hd + cfg[i].hf;
    if (ox[i] == 10'(hs_start) && prev_x[i] != 10'(hs_start)) t_hs_start[i] = n;
    if (prev_hs[i] && !ohs[i]) begin
      check($sformatf("u%0d.hs_delay", i), 32'(n - t_hs_start[i]), 32'(cfg[i].dly + 1));
      t_hs_fall[i] = n;
    end
    if (!prev_hs[i] && ohs[i])
      check($sformatf("u%0d.hs_width", i), 32'(n - t_hs_fall[i]), 32'(cfg[i].hs * cfg[i].div));
    if (prev_vs[i] && !ovs[i]) t_vs_fall[i] = n;
    if (!prev_vs[i] && ovs[i])
      check($sformatf("u%0d.vs_width", i), 32'(n - t_vs_fall[i]),
            32'(cfg[i].vs * h_tot(cfg[i]) * cfg[i].div));
    if (oft[i]) begin
      check($sformatf("u%0d.ft_period", i), 32'(n - t_ft[i]),
            32'(h_tot(cfg[i]) * v_tot(cfg[i]) * cfg[i].div));
      t_ft[i] = n;
    end
    if (white_mode) begin
      if (orgb[i] == BLACK) begin
        if (run_ok[i] && run_len[i] > 0)
          check($sformatf("u%0d.white_run", i), 32'(run_len[i]), 32'(cfg[i].hd * cfg[i].div));
        run_len[i] = 0;
        run_ok[i]  = 1'b1;
      end else begin
        run_len[i]++;
      end
    end
    prev_x[i]  = ox[i];
    prev_hs[i] = ohs[i];
    prev_vs[i] = ovs[i];
  endtask

  task automatic reset_trackers();
    for (int i = 0; i < NI; i++) begin
      t_hs_start[i] = -1;
      t_hs_fall[i]  = -1;
      t_vs_fall[i]  = -1;
      t_ft[i]       = 0;
      run_len[i]    = 0;
      run_ok[i]     = 1'b0;
      prev_x[i]     = '0;
      prev_hs[i]    = 1'b1;
      prev_vs[i]    = 1'b1;
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      g_edge = graph_rgb;
      @(posedge CLK);
      n++;
      @(negedge CLK);
      for (int i = 0; i < NI; i++) begin
        check_inst(i);
        track_inst(i);
      end
      graph_rgb = white_mode ? WHITE : 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 2};
    cfg[1] = '{20, 4, 6, 5, 12, 2, 3, 4, 1, 2};
    cfg[2] = '{20, 4, 6, 5, 12, 2, 3, 4, 4, 2};
    cfg[3] = '{20, 4, 6, 5, 12, 2, 3, 4, 1, 0};
    white_mode = 1'b0;
    graph_rgb  = 3'b000;
    g_edge     = 3'b000;
    n          = 0;
    RESET      = 1'b1;
    reset_trackers();

    // Power-on reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < NI; i++) check_inst(i);
    RESET = 1'b0;

    // Random colour, raster/sync/frame timing on all configurations
    run(6000);

    // Solid white: each visible line must come out as one unbroken run
    white_mode = 1'b1;
    graph_rgb  = WHITE;
    for (int i = 0; i < NI; i++) begin
      run_len[i] = 0;
      run_ok[i]  = 1'b0;
    end
    run(3000);
    white_mode = 1'b0;

    // Asynchronous reset mid-frame, between clock edges
    #2 RESET = 1'b1;
    #1;
    n = 0;
    for (int i = 0; i < NI; i++) check_inst(i);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < NI; i++) check_inst(i);
    RESET = 1'b0;
    reset_trackers();
    run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
